// File: rtl/mult_share_pkg.sv
// Shared types and widths for the shared-multiplier controller.
// Operand/product widths, settle-counter sizing and the controller state encoding.
package mult_share_pkg;
  localparam int OPW        = 4;
  localparam int PRODW      = 8;
  localparam int SETTLE_MAX = 15;
  localparam int CNTW       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/mult.sv
// Combinational unsigned 4x4 multiplier with bit-level ports.
// Zero latency; no flow control, the caller holds operands stable.
module mult (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  output logic product0,
  output logic product1,
  output logic product2,
  output logic product3,
  output logic product4,
  output logic product5,
  output logic product6,
  output logic product7
);
  logic [7:0] a_ext;
  logic [7:0] b_ext;
  logic [7:0] p;

  assign a_ext = {4'b0000, A3, A2, A1, A0};
  assign b_ext = {4'b0000, B3, B2, B1, B0};
  assign p     = a_ext * b_ext;

  assign {product7, product6, product5, product4,
          product3, product2, product1, product0} = p;
endmodule

// File: rtl/mult_rr_arb2.sv
// Two-way round-robin grant: one-hot ready for whichever requester is owed the slot.
// Combinational; grants nothing while the accept window is closed.
module mult_rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  input  logic       window_open,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    if (window_open) begin
      if (valid0 && valid1) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = {valid1, valid0};
      end
    end
  end
endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational multiplier between two requesters; product returned SETTLE_CYCLES edges after accept.
// A held response blocks new accepts; a response handshake can accept the next pair on the same edge.
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_a,
  input  logic [OPW-1:0]   req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_a,
  input  logic [OPW-1:0]   req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [PRODW-1:0] rsp_product,
  output logic             busy
);
  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]    op_a_q, op_a_d;
  logic [OPW-1:0]    op_b_q, op_b_d;
  logic [PRODW-1:0]  prod_q, prod_d;
  logic              tag_q, tag_d;
  logic              id_q, id_d;
  logic              last_grant_q, last_grant_d;

  logic              window_open;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic [PRODW-1:0]  mult_p;

  assign window_open = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

  mult_rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant_q),
    .window_open (window_open),
    .grant       (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = (req0_valid & grant[0]) | (req1_valid & grant[1]);
  assign sel        = grant[1];

  // Multiplier sees only registered operands, so its output is stable through the settle window.
  mult u_mult (
    .A0       (op_a_q[0]),
    .A1       (op_a_q[1]),
    .A2       (op_a_q[2]),
    .A3       (op_a_q[3]),
    .B0       (op_b_q[0]),
    .B1       (op_b_q[1]),
    .B2       (op_b_q[2]),
    .B3       (op_b_q[3]),
    .product0 (mult_p[0]),
    .product1 (mult_p[1]),
    .product2 (mult_p[2]),
    .product3 (mult_p[3]),
    .product4 (mult_p[4]),
    .product5 (mult_p[5]),
    .product6 (mult_p[6]),
    .product7 (mult_p[7])
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    prod_d       = prod_q;
    tag_d        = tag_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;

    if (accept) begin
      op_a_d       = sel ? req1_a : req0_a;
      op_b_d       = sel ? req1_b : req0_b;
      tag_d        = sel;
      last_grant_d = sel;
      cnt_d        = CNTW'(SETTLE_CYCLES - 1);
    end

    case (state_q)
      IDLE: begin
        if (accept) state_d = CALC;
      end
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          prod_d  = mult_p;
          id_d    = tag_q;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = accept ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      prod_q       <= '0;
      tag_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      prod_q       <= prod_d;
      tag_q        <= tag_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: three instances with settle times 2, 1 and 15.
module tb_mult_share_ctrl;
  logic       clk;
  logic       rst;
  logic       v0   [3];
  logic       v1   [3];
  logic       rr   [3];
  logic [3:0] a0   [3];
  logic [3:0] b0   [3];
  logic [3:0] a1   [3];
  logic [3:0] b1   [3];
  logic       rdy0 [3];
  logic       rdy1 [3];
  logic       rv   [3];
  logic       rid  [3];
  logic       bsy  [3];
  logic [7:0] rp   [3];

  int tests;
  int fails;

  mult_share_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_id(rid[0]), .rsp_product(rp[0]),
    .busy(bsy[0])
  );

  mult_share_ctrl #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_id(rid[1]), .rsp_product(rp[1]),
    .busy(bsy[1])
  );

  mult_share_ctrl #(.SETTLE_CYCLES(15)) dut_s15 (
    .clk(clk), .rst(rst),
    .req0_valid(v0[2]), .req0_ready(rdy0[2]), .req0_a(a0[2]), .req0_b(b0[2]),
    .req1_valid(v1[2]), .req1_ready(rdy1[2]), .req1_a(a1[2]), .req1_b(b1[2]),
    .rsp_valid(rv[2]), .rsp_ready(rr[2]), .rsp_id(rid[2]), .rsp_product(rp[2]),
    .busy(bsy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input bit sel, input logic vld,
                        input logic [3:0] a, input logic [3:0] b);
    if (sel) begin
      v1[d] = vld; a1[d] = a; b1[d] = b;
    end else begin
      v0[d] = vld; a0[d] = a; b0[d] = b;
    end
  endtask

  // Counts negedges after the caller's point until rsp_valid; -1 on timeout.
  task automatic wait_rsp(input int d, input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (rv[d]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b1;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation on instance d; lat is that instance's settle time.
  task automatic run_op(input int d, input bit sel, input logic [3:0] a,
                        input logic [3:0] b, input logic [7:0] exp, input int lat,
                        input bit verbose);
    int n;
    @(negedge clk);
    set_in(d, sel, 1'b1, a, b);
    rr[d] = 1'b1;
    #1;
    if (verbose) begin
      chk("single_ready_granted", sel ? int'(rdy1[d]) : int'(rdy0[d]), 1);
      chk("single_ready_other",   sel ? int'(rdy0[d]) : int'(rdy1[d]), 0);
    end
    @(posedge clk);
    #1;
    set_in(d, sel, 1'b0, ~a, ~b);
    wait_rsp(d, lat + 6, n);
    chk("latency", n - 1, lat);
    if (n > 0) begin
      chk("product", int'(rp[d]), int'(exp));
      if (verbose) chk("rsp_id", int'(rid[d]), int'(sel));
    end
    @(negedge clk);
    if (verbose) begin
      chk("post_rsp_valid", int'(rv[d]), 0);
      chk("post_busy", int'(bsy[d]), 0);
    end else if (rv[d] || bsy[d]) begin
      chk("post_idle", 1, 0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int cyc;
    int nrsp;
    int rsp_cyc[8];
    bit rsp_id_seen[8];
    bit seen_bad;

    tests = 0;
    fails = 0;
    rst = 1'b1;

    vecs[0] = '{sel: 1'b0, a: 4'd13, b: 4'd11, exp: 8'd143};
    vecs[1] = '{sel: 1'b1, a: 4'd7,  b: 4'd9,  exp: 8'd63};
    vecs[2] = '{sel: 1'b0, a: 4'd15, b: 4'd15, exp: 8'd225};
    vecs[3] = '{sel: 1'b1, a: 4'd0,  b: 4'd15, exp: 8'd0};
    vecs[4] = '{sel: 1'b0, a: 4'd1,  b: 4'd1,  exp: 8'd1};
    vecs[5] = '{sel: 1'b1, a: 4'd12, b: 4'd10, exp: 8'd120};

    // Reset: readies stay low even with valids asserted.
    do_reset();
    @(negedge clk);
    rst = 1'b1;
    v0[0] = 1'b1; v1[0] = 1'b1;
    #1;
    chk("rst_req0_ready", int'(rdy0[0]), 0);
    chk("rst_req1_ready", int'(rdy1[0]), 0);
    @(negedge clk);
    chk("rst_rsp_valid", int'(rv[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_product", int'(rp[0]), 0);
    chk("rst_id", int'(rid[0]), 0);
    v0[0] = 1'b0; v1[0] = 1'b0;
    rst = 1'b0;

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(0, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, 2, 1'b1);
    end

    // Both valid after reset: req0 first, req1 accepted on the response edge.
    do_reset();
    @(negedge clk);
    set_in(0, 1'b0, 1'b1, 4'd3, 4'd5);
    set_in(0, 1'b1, 1'b1, 4'd15, 4'd15);
    #1;
    chk("both_first_rdy0", int'(rdy0[0]), 1);
    chk("both_first_rdy1", int'(rdy1[0]), 0);
    @(posedge clk);
    #1;
    v0[0] = 1'b0;
    wait_rsp(0, 8, n);
    chk("both_lat0", n - 1, 2);
    chk("both_prod0", int'(rp[0]), 15);
    chk("both_id0", int'(rid[0]), 0);
    chk("both_rdy1_on_rsp", int'(rdy1[0]), 1);
    @(posedge clk);
    #1;
    v1[0] = 1'b0;
    wait_rsp(0, 8, n);
    chk("both_lat1", n - 1, 2);
    chk("both_prod1", int'(rp[0]), 225);
    chk("both_id1", int'(rid[0]), 1);
    @(negedge clk);
    chk("both_idle", int'(bsy[0]), 0);

    // Back-pressure: response held with rsp_ready low, requesters locked out.
    @(negedge clk);
    set_in(0, 1'b1, 1'b1, 4'd7, 4'd9);
    rr[0] = 1'b0;
    @(posedge clk);
    #1;
    set_in(0, 1'b1, 1'b0, 4'd0, 4'd0);
    wait_rsp(0, 8, n);
    chk("bp_lat", n - 1, 2);
    v0[0] = 1'b1; v1[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", int'(rv[0]), 1);
      chk("bp_prod", int'(rp[0]), 63);
      chk("bp_id", int'(rid[0]), 1);
      chk("bp_rdy0", int'(rdy0[0]), 0);
      chk("bp_rdy1", int'(rdy1[0]), 0);
      @(negedge clk);
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    rr[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(rv[0]), 0);
    chk("bp_release_busy", int'(bsy[0]), 0);
    @(negedge clk);
    chk("bp_no_second", int'(rv[0]), 0);

    // Continuous contention: last grant was req1, so ids alternate starting at 0.
    @(negedge clk);
    set_in(0, 1'b0, 1'b1, 4'd2, 4'd3);
    set_in(0, 1'b1, 1'b1, 4'd5, 4'd7);
    nrsp = 0;
    for (cyc = 0; cyc < 60 && nrsp < 8; cyc++) begin
      @(negedge clk);
      if (rv[0]) begin
        rsp_cyc[nrsp] = cyc;
        rsp_id_seen[nrsp] = rid[0];
        chk("rr_prod", int'(rp[0]), rid[0] ? 35 : 6);
        nrsp++;
      end
    end
    v0[0] = 1'b0; v1[0] = 1'b0;
    chk("rr_count", nrsp, 8);
    for (int i = 0; i < nrsp; i++) begin
      chk("rr_id", int'(rsp_id_seen[i]), i % 2);
      if (i > 0) chk("rr_spacing", rsp_cyc[i] - rsp_cyc[i-1], 3);
    end
    @(negedge clk);
    chk("rr_drain_busy", int'(bsy[0]), 0);

    // Reset during CALC discards the in-flight (15,15).
    @(negedge clk);
    set_in(0, 1'b0, 1'b1, 4'd15, 4'd15);
    @(posedge clk);
    #1;
    v0[0] = 1'b0;
    @(negedge clk);
    chk("midrst_in_calc", int'(bsy[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(bsy[0]), 0);
    chk("midrst_valid", int'(rv[0]), 0);
    chk("midrst_prod", int'(rp[0]), 0);
    seen_bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rv[0] || rp[0] == 8'd225) seen_bad = 1'b1;
    end
    chk("midrst_no_rsp", int'(seen_bad), 0);

    // Exhaustive operand sweep via req1 at settle times 1 and 15.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(1, 1'b1, a[3:0], b[3:0], 8'(a * b), 1, 1'b0);
      end
    end
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(2, 1'b1, a[3:0], b[3:0], 8'(a * b), 15, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
